// File: rtl/sprite_scheduler_pkg.sv
// Shared types and constants for the sprite scheduler and its sprite table.
package sprite_scheduler_pkg;

  localparam int unsigned XW        = 11;
  localparam int unsigned YW        = 10;
  localparam int unsigned PW        = 6;
  localparam int unsigned BASE_SIZE = 16;

  // RRGGBB value keyed out as transparent unless overridden
  localparam logic [PW-1:0] TKEY_DEFAULT = 6'h00;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StScan  = 2'd1,
    StDrain = 2'd2
  } state_t;

  // Geometry of one sprite entry; the bank address is kept alongside since its
  // width is a module parameter.
  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          width;
    logic          height;
    logic          enable;
  } sprite_geom_t;

  // Extent in pixels: 0 -> 16, 1 -> 32
  function automatic logic [XW-1:0] sprite_span(input logic big);
    return XW'(BASE_SIZE) << big;
  endfunction

endpackage

// File: rtl/sprite_table.sv
// Double-buffered sprite table: game logic writes the shadow copy, a commit
// copies it into the active copy that the scanner reads.
module sprite_table
  import sprite_scheduler_pkg::*;
#(
  parameter int unsigned SIZE = 4,
  parameter int unsigned NSPR = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [2:0]         wr_idx,
  input  sprite_geom_t       wr_geom,
  input  logic [SIZE-1:0]    wr_addr,
  input  logic               commit,
  input  logic [2:0]         rd_idx,
  output sprite_geom_t       rd_geom,
  output logic [SIZE-1:0]    rd_addr
);

  sprite_geom_t    shadow_geom_q [NSPR];
  logic [SIZE-1:0] shadow_addr_q [NSPR];
  sprite_geom_t    active_geom_q [NSPR];
  logic [SIZE-1:0] active_addr_q [NSPR];

  // Shadow write port; indices at or above NSPR match no entry and are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSPR; i++) begin
        shadow_geom_q[i] <= '0;
        shadow_addr_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NSPR; i++) begin
        if (wr_en && (wr_idx == 3'(i))) begin
          shadow_geom_q[i] <= wr_geom;
          shadow_addr_q[i] <= wr_addr;
        end
      end
    end
  end

  // Commit copies the pre-write shadow, so a same-cycle write waits for the next commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSPR; i++) begin
        active_geom_q[i] <= '0;
        active_addr_q[i] <= '0;
      end
    end else if (commit) begin
      for (int i = 0; i < NSPR; i++) begin
        active_geom_q[i] <= shadow_geom_q[i];
        active_addr_q[i] <= shadow_addr_q[i];
      end
    end
  end

  // Indexed read of the active copy
  always_comb begin
    rd_geom = '0;
    rd_addr = '0;
    for (int i = 0; i < NSPR; i++) begin
      if (rd_idx == 3'(i)) begin
        rd_geom = active_geom_q[i];
        rd_addr = active_addr_q[i];
      end
    end
  end

endmodule

// File: rtl/sprite_scheduler.sv
// Sprite scheduler: per pixel strobe, walks the active sprite table in priority
// order over the single bitmap-bank read port and composites the first opaque
// texel. Fixed-length scan gives deterministic latency of NSPR+2 cycles.
module sprite_scheduler
  import sprite_scheduler_pkg::*;
#(
  parameter int unsigned   SIZE = 4,
  parameter int unsigned   NSPR = 4,
  parameter logic [PW-1:0] TKEY = TKEY_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pix_en,
  input  logic [10:0]     hcnt,
  input  logic [9:0]      vcnt,
  input  logic            frame_start,
  input  logic            wr_en,
  input  logic [2:0]      wr_idx,
  input  logic [10:0]     wr_x,
  input  logic [9:0]      wr_y,
  input  logic [SIZE-1:0] wr_addr,
  input  logic            wr_width,
  input  logic            wr_height,
  input  logic            wr_enable,
  output logic [SIZE-1:0] bank_addr,
  output logic            bank_width,
  output logic [4:0]      bank_hpos,
  output logic [4:0]      bank_vpos,
  input  logic [5:0]      bank_pixel,
  output logic [5:0]      pixel_out,
  output logic            pixel_hit,
  output logic            pixel_valid,
  output logic            busy,
  output logic            overrun
);

  state_t          state_q;
  logic [XW-1:0]   hcnt_q;
  logic [YW-1:0]   vcnt_q;
  logic [2:0]      k_q;
  logic            hit_d_q;
  logic            cand_hit_q;
  logic [PW-1:0]   cand_q;
  logic            commit_pend_q;

  sprite_geom_t    rd_geom;
  logic [SIZE-1:0] rd_addr;
  sprite_geom_t    wr_geom;
  logic            commit;
  logic [XW-1:0]   dx;
  logic [XW-1:0]   dy;
  logic            hit;
  logic            take;
  logic            final_hit;
  logic [PW-1:0]   final_pix;

  assign wr_geom = '{x: wr_x, y: wr_y, width: wr_width, height: wr_height, enable: wr_enable};

  // Commit immediately when idle, otherwise on the DRAIN -> IDLE edge
  assign commit = ((state_q == StIdle) && frame_start) ||
                  ((state_q == StDrain) && (commit_pend_q || frame_start));

  sprite_table #(
    .SIZE (SIZE),
    .NSPR (NSPR)
  ) u_table (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_geom (wr_geom),
    .wr_addr (wr_addr),
    .commit  (commit),
    .rd_idx  (k_q),
    .rd_geom (rd_geom),
    .rd_addr (rd_addr)
  );

  // Hit test: wrapping subtraction turns left/above positions into huge offsets
  always_comb begin
    dx  = hcnt_q - rd_geom.x;
    dy  = {1'b0, vcnt_q} - {1'b0, rd_geom.y};
    hit = rd_geom.enable && (dx < sprite_span(rd_geom.width)) &&
          (dy < sprite_span(rd_geom.height));
  end

  // Bank request for the sprite being issued, whether or not it hits
  always_comb begin
    bank_addr  = '0;
    bank_width = 1'b0;
    bank_hpos  = '0;
    bank_vpos  = '0;
    if (state_q == StScan) begin
      bank_addr  = rd_addr;
      bank_width = rd_geom.width;
      bank_hpos  = dx[4:0];
      bank_vpos  = dy[4:0];
    end
  end

  // Evaluate stage: the first opaque hit in issue order is kept
  always_comb begin
    take      = hit_d_q && (bank_pixel != TKEY) && !cand_hit_q;
    final_hit = cand_hit_q || take;
    final_pix = cand_hit_q ? cand_q : (take ? bank_pixel : '0);
  end

  assign busy = (state_q != StIdle);

  // Scan FSM with registered compositor outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      k_q           <= '0;
      hit_d_q       <= 1'b0;
      cand_hit_q    <= 1'b0;
      cand_q        <= '0;
      commit_pend_q <= 1'b0;
      pixel_out     <= '0;
      pixel_hit     <= 1'b0;
      pixel_valid   <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      hit_d_q     <= 1'b0;
      if (take) begin
        cand_q     <= bank_pixel;
        cand_hit_q <= 1'b1;
      end
      case (state_q)
        StIdle: begin
          if (pix_en) begin
            hcnt_q     <= hcnt;
            vcnt_q     <= vcnt;
            cand_hit_q <= 1'b0;
            cand_q     <= '0;
            k_q        <= '0;
            state_q    <= StScan;
          end
        end
        StScan: begin
          hit_d_q <= hit;
          if (pix_en) overrun <= 1'b1;
          if (frame_start) commit_pend_q <= 1'b1;
          if (k_q == 3'(NSPR - 1)) begin
            state_q <= StDrain;
          end else begin
            k_q <= k_q + 3'd1;
          end
        end
        StDrain: begin
          if (pix_en) overrun <= 1'b1;
          pixel_out     <= final_hit ? final_pix : 6'h00;
          pixel_hit     <= final_hit;
          pixel_valid   <= 1'b1;
          commit_pend_q <= 1'b0;
          state_q       <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_scheduler.sv
// Self-checking bench for sprite_scheduler: a bitmap-bank model, a reference
// model of the double-buffered table, and a scoreboard of expected pixels.
module tb_sprite_scheduler;

  localparam int unsigned SIZE = 4;
  localparam int unsigned NSPR = 4;

  typedef struct {
    logic [10:0] x;
    logic [9:0]  y;
    logic [3:0]  addr;
    logic        w;
    logic        h;
    logic        en;
  } spr_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            pix_en = 1'b0;
  logic [10:0]     hcnt = '0;
  logic [9:0]      vcnt = '0;
  logic            frame_start = 1'b0;
  logic            wr_en = 1'b0;
  logic [2:0]      wr_idx = '0;
  logic [10:0]     wr_x = '0;
  logic [9:0]      wr_y = '0;
  logic [SIZE-1:0] wr_addr = '0;
  logic            wr_width = 1'b0;
  logic            wr_height = 1'b0;
  logic            wr_enable = 1'b0;
  logic [SIZE-1:0] bank_addr;
  logic            bank_width;
  logic [4:0]      bank_hpos;
  logic [4:0]      bank_vpos;
  logic [5:0]      bank_pixel = '0;
  logic [5:0]      pixel_out;
  logic            pixel_hit;
  logic            pixel_valid;
  logic            busy;
  logic            overrun;

  int n_checks = 0;
  int n_errors = 0;
  int n_valid  = 0;
  int n_pushed = 0;

  logic [6:0] exp_q[$];
  spr_t       sh[NSPR];
  spr_t       ac[NSPR];
  logic       fix_en[16];
  logic [5:0] fix_val[16];

  sprite_scheduler #(
    .SIZE (SIZE),
    .NSPR (NSPR),
    .TKEY (6'h00)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pix_en      (pix_en),
    .hcnt        (hcnt),
    .vcnt        (vcnt),
    .frame_start (frame_start),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .wr_addr     (wr_addr),
    .wr_width    (wr_width),
    .wr_height   (wr_height),
    .wr_enable   (wr_enable),
    .bank_addr   (bank_addr),
    .bank_width  (bank_width),
    .bank_hpos   (bank_hpos),
    .bank_vpos   (bank_vpos),
    .bank_pixel  (bank_pixel),
    .pixel_out   (pixel_out),
    .pixel_hit   (pixel_hit),
    .pixel_valid (pixel_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // Bank contents: a nonzero pattern, or a fixed value per address when overridden
  function automatic logic [5:0] texel(input logic [3:0] a, input logic [4:0] hp,
                                       input logic [4:0] vp);
    if (fix_en[a]) return fix_val[a];
    return {1'b1, vp[1:0] ^ hp[4:3], hp[2:0]};
  endfunction

  // Bank model: one-cycle read latency
  always @(posedge clk) bank_pixel <= texel(bank_addr, bank_hpos, bank_vpos);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard consumer
  always @(negedge clk) begin
    if (!rst && pixel_valid) begin
      logic [6:0] e;
      n_valid++;
      if (exp_q.size() == 0) begin
        check_eq("spurious_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("pixel_hit", {31'd0, pixel_hit}, {31'd0, e[6]});
        check_eq("pixel_out", {26'd0, pixel_out}, {26'd0, e[5:0]});
      end
    end
  end

  task automatic model_pixel(input logic [10:0] h, input logic [9:0] v, output logic [6:0] r);
    r = '0;
    for (int k = 0; k < NSPR; k++) begin
      logic [10:0] dx, dy, sw, shh;
      logic [5:0]  t;
      dx  = h - ac[k].x;
      dy  = {1'b0, v} - {1'b0, ac[k].y};
      sw  = ac[k].w ? 11'd32 : 11'd16;
      shh = ac[k].h ? 11'd32 : 11'd16;
      t   = texel(ac[k].addr, dx[4:0], dy[4:0]);
      if (!r[6] && ac[k].en && dx < sw && dy < shh && t != 6'h00) r = {1'b1, t};
    end
  endtask

  task automatic write_spr(input int idx, input logic [10:0] x, input logic [9:0] y,
                           input logic [3:0] a, input logic w, input logic h, input logic en,
                           input logic with_commit);
    wr_idx = 3'(idx); wr_x = x; wr_y = y; wr_addr = a;
    wr_width = w; wr_height = h; wr_enable = en;
    wr_en = 1'b1; frame_start = with_commit;
    @(posedge clk); #1;
    wr_en = 1'b0; frame_start = 1'b0;
    if (with_commit) ac = sh;
    if (idx < NSPR) sh[idx] = '{x: x, y: y, addr: a, w: w, h: h, en: en};
  endtask

  task automatic commit_idle();
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    ac = sh;
  endtask

  task automatic start_pixel(input logic [10:0] h, input logic [9:0] v, input logic push);
    logic [6:0] r;
    model_pixel(h, v, r);
    if (push) begin exp_q.push_back(r); n_pushed++; end
    hcnt = h; vcnt = v; pix_en = 1'b1;
    @(posedge clk); #1;
    pix_en = 1'b0;
  endtask

  // Checks every bank issue, busy, and the exact pixel_valid cycle; optional
  // frame_start / pix_en pulses at a chosen issue slot.
  task automatic scan_body(input logic [10:0] h, input logic [9:0] v,
                           input int fs_at, input int pe_at);
    for (int k = 0; k < NSPR; k++) begin
      logic [10:0] dx, dy;
      frame_start = 1'b0; pix_en = 1'b0;
      dx = h - ac[k].x;
      dy = {1'b0, v} - {1'b0, ac[k].y};
      check_eq($sformatf("bank_addr%0d", k), {28'd0, bank_addr}, {28'd0, ac[k].addr});
      check_eq($sformatf("bank_width%0d", k), {31'd0, bank_width}, {31'd0, ac[k].w});
      check_eq($sformatf("bank_hpos%0d", k), {27'd0, bank_hpos}, {27'd0, dx[4:0]});
      check_eq($sformatf("bank_vpos%0d", k), {27'd0, bank_vpos}, {27'd0, dy[4:0]});
      check_eq("busy_scan", {31'd0, busy}, 1);
      if (k == fs_at) frame_start = 1'b1;
      if (k == pe_at) pix_en = 1'b1;
      @(posedge clk); #1;
    end
    frame_start = 1'b0; pix_en = 1'b0;
    check_eq("busy_drain", {31'd0, busy}, 1);
    check_eq("valid_early", {31'd0, pixel_valid}, 0);
    @(posedge clk); #1;
    check_eq("valid_latency", {31'd0, pixel_valid}, 1);
    check_eq("busy_done", {31'd0, busy}, 0);
    @(posedge clk); #1;
  endtask

  task automatic run_pixel(input logic [10:0] h, input logic [9:0] v);
    start_pixel(h, v, 1'b1);
    scan_body(h, v, -1, -1);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_bank_addr", {28'd0, bank_addr}, 0);
    check_eq("rst_bank_pos", {22'd0, bank_width, bank_hpos, bank_vpos}, 0);
    check_eq("rst_pixel", {25'd0, pixel_hit, pixel_out}, 0);
    check_eq("rst_valid", {31'd0, pixel_valid}, 0);
    check_eq("rst_busy", {31'd0, busy}, 0);
    check_eq("rst_overrun", {31'd0, overrun}, 0);
  endtask

  task automatic clear_model();
    for (int i = 0; i < NSPR; i++) begin
      sh[i] = '{x: '0, y: '0, addr: '0, w: 1'b0, h: 1'b0, en: 1'b0};
    end
    ac = sh;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin fix_en[i] = 1'b0; fix_val[i] = '0; end
    clear_model();
    rst = 1'b1;
    #1;
    check_reset_outputs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset mid-scan
    write_spr(0, 11'd100, 10'd50, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    commit_idle();
    start_pixel(11'd105, 10'd53, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_reset_outputs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    clear_model();
    repeat (4) @(posedge clk);
    #1;
    run_pixel(11'd105, 10'd53);

    // Single sprite
    write_spr(0, 11'd100, 10'd50, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    commit_idle();
    run_pixel(11'd105, 10'd53);
    run_pixel(11'd0, 10'd0);

    // Overlap with transparency
    write_spr(2, 11'd96, 10'd48, 4'd8, 1'b1, 1'b1, 1'b1, 1'b0);
    commit_idle();
    fix_en[2] = 1'b1; fix_val[2] = 6'h00;
    fix_en[8] = 1'b1; fix_val[8] = 6'h30;
    run_pixel(11'd105, 10'd53);
    fix_val[2] = 6'h15;
    run_pixel(11'd105, 10'd53);
    fix_en[2] = 1'b0; fix_en[8] = 1'b0;
    run_pixel(11'd120, 10'd70);

    // Width-32 boundary
    write_spr(3, 11'd100, 10'd400, 4'd12, 1'b1, 1'b0, 1'b1, 1'b0);
    commit_idle();
    run_pixel(11'd131, 10'd405);
    run_pixel(11'd132, 10'd405);
    run_pixel(11'd99, 10'd405);
    run_pixel(11'd100, 10'd415);
    run_pixel(11'd100, 10'd416);

    // Double buffer
    write_spr(1, 11'd300, 10'd300, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    commit_idle();
    write_spr(1, 11'd200, 10'd300, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    run_pixel(11'd305, 10'd305);
    run_pixel(11'd205, 10'd305);
    start_pixel(11'd305, 10'd305, 1'b1);
    scan_body(11'd305, 10'd305, 0, -1);
    ac = sh;
    run_pixel(11'd205, 10'd305);
    run_pixel(11'd305, 10'd305);
    write_spr(1, 11'd400, 10'd300, 4'd5, 1'b0, 1'b0, 1'b1, 1'b1);
    run_pixel(11'd205, 10'd305);
    run_pixel(11'd405, 10'd305);
    commit_idle();
    run_pixel(11'd405, 10'd305);
    // Out-of-range index must not disturb any entry
    write_spr(5, 11'd0, 10'd0, 4'd1, 1'b1, 1'b1, 1'b1, 1'b0);
    commit_idle();
    run_pixel(11'd5, 10'd5);

    // Overrun
    check_eq("overrun_pre", {31'd0, overrun}, 0);
    start_pixel(11'd405, 10'd305, 1'b1);
    scan_body(11'd405, 10'd305, -1, 2);
    check_eq("overrun_set", {31'd0, overrun}, 1);
    run_pixel(11'd105, 10'd53);
    check_eq("overrun_sticky", {31'd0, overrun}, 1);
    repeat (4) @(posedge clk);
    #1;
    check_eq("valid_count", n_valid, n_pushed);
    check_eq("queue_empty", exp_q.size(), 0);
    rst = 1'b1;
    #1;
    check_eq("overrun_cleared", {31'd0, overrun}, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
